// File: rtl/rrp_arbiter_burst_if.sv
// Handshake bundle between WIDTH FWFT sources and the merged readout stream of
// rrp_arbiter_burst. The master modport is the arbiter side.
interface rrp_arbiter_burst_if #(
  parameter int unsigned WIDTH      = 11,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned ChW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]            WRITE_REQ;
  logic [WIDTH-1:0]            HOLD_REQ;
  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN;
  logic [WIDTH-1:0]            READ_GRANT;
  logic                        READY_OUT;
  logic                        WRITE_OUT;
  logic [DATA_WIDTH-1:0]       DATA_OUT;
  logic [ChW-1:0]              ACTIVE_CH;

  modport master (
    input  WRITE_REQ,
    input  HOLD_REQ,
    input  DATA_IN,
    input  READY_OUT,
    output READ_GRANT,
    output WRITE_OUT,
    output DATA_OUT,
    output ACTIVE_CH
  );

  modport slave (
    output WRITE_REQ,
    output HOLD_REQ,
    output DATA_IN,
    output READY_OUT,
    input  READ_GRANT,
    input  WRITE_OUT,
    input  DATA_OUT,
    input  ACTIVE_CH
  );
endinterface

// File: rtl/rrp_arbiter_burst.sv
// Round-robin burst arbiter merging WIDTH FWFT sources into one registered stream.
// Define ARB_BURST_EN to enable multi-word bursts (up to MAX_BURST); otherwise it rotates every word.
module rrp_arbiter_burst #(
  parameter int unsigned WIDTH      = 11,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                CLK,
  input  logic                RST,
  rrp_arbiter_burst_if.master bus
);
  localparam int unsigned ChW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef logic [ChW-1:0] ch_t;

  if (WIDTH < 1 || WIDTH > 64 || MAX_BURST < 1 || MAX_BURST > 256) begin : g_param_check
    $error("rrp_arbiter_burst: WIDTH or MAX_BURST out of range");
  end

  ch_t                   cur_q;
  logic                  wout_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  ld;
  logic                  req_cur;
  logic                  hold_cur;
  logic                  burst_ok;
  logic                  rot_vld;
  ch_t                   rot_sel;
  logic                  sel_vld;
  ch_t                   sel;
  logic                  grant;
  logic [WIDTH-1:0]      grant_vec;
  logic [DATA_WIDTH-1:0] din [WIDTH];

  for (genvar k = 0; k < WIDTH; k++) begin : g_unpack
    assign din[k] = bus.DATA_IN[k*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef ARB_BURST_EN
  localparam int unsigned BcW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BcW-1:0] BcMax = BcW'(MAX_BURST - 1);

  logic [BcW-1:0] bcnt_q;

  assign burst_ok = (bcnt_q < BcMax);
`else
  assign burst_ok = 1'b0;
`endif

  assign ld       = ~wout_q | bus.READY_OUT;
  assign req_cur  = bus.WRITE_REQ[cur_q];
  assign hold_cur = bus.HOLD_REQ[cur_q];

  // Scan cur+1 .. cur+WIDTH (mod WIDTH) so the current channel is checked last.
  always_comb begin
    int unsigned idx_w;
    ch_t         idx;
    rot_vld = 1'b0;
    rot_sel = '0;
    for (int unsigned i = 1; i <= WIDTH; i++) begin
      idx_w = 32'(cur_q) + i;
      if (idx_w >= WIDTH) begin
        idx_w = idx_w - WIDTH;
      end
      idx = ch_t'(idx_w);
      if (!rot_vld && bus.WRITE_REQ[idx]) begin
        rot_vld = 1'b1;
        rot_sel = idx;
      end
    end
  end

  // A held channel never yields: with no word pending the arbiter stalls.
  always_comb begin
    sel_vld = 1'b0;
    sel     = cur_q;
    if (hold_cur) begin
      sel_vld = req_cur;
    end else if (req_cur && burst_ok) begin
      sel_vld = 1'b1;
    end else begin
      sel_vld = rot_vld;
      sel     = rot_sel;
    end
  end

  assign grant = ld & sel_vld & ~RST;

  always_comb begin
    grant_vec = '0;
    if (grant) begin
      grant_vec[sel] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_q  <= ch_t'(WIDTH - 1);
      wout_q <= 1'b0;
      data_q <= '0;
`ifdef ARB_BURST_EN
      bcnt_q <= '0;
`endif
    end else if (ld) begin
      wout_q <= grant;
      if (grant) begin
        data_q <= din[sel];
        cur_q  <= sel;
`ifdef ARB_BURST_EN
        if (sel != cur_q) begin
          bcnt_q <= '0;
        end else if (bcnt_q != BcMax) begin
          bcnt_q <= bcnt_q + 1'b1;
        end
`endif
      end
    end
  end

  assign bus.READ_GRANT = grant_vec;
  assign bus.WRITE_OUT  = wout_q;
  assign bus.DATA_OUT   = data_q;
  assign bus.ACTIVE_CH  = cur_q;
endmodule

// File: tb/tb_rrp_arbiter_burst.sv
// Scoreboard bench for rrp_arbiter_burst: directed scenarios plus randomized traffic,
// checked against a rule-level reference model (honours ARB_BURST_EN like the DUT).
module tb_rrp_arbiter_burst;
  localparam int W  = 11;
  localparam int DW = 32;
  localparam int MB = 4;
`ifdef ARB_BURST_EN
  localparam int LIMIT = MB;
`else
  localparam int LIMIT = 1;
`endif

  typedef struct {
    logic [31:0] data;
    int          ch;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  rrp_arbiter_burst_if #(.WIDTH(W), .DATA_WIDTH(DW)) bus ();

  rrp_arbiter_burst #(.WIDTH(W), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]  fifo [W][$];
  exp_t         exp_q[$];
  logic [W-1:0] mask;
  logic [W-1:0] hold;
  logic [W-1:0] cur_req;
  bit           ready;
  int           seq = 0;

  // Reference model state: last granted channel, words in the current burst, output valid.
  int m_cur;
  int m_run;
  bit m_wout;
  int last_ch;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic bit has(input logic [W-1:0] v, input int c);
    logic [W-1:0] t;
    t = v >> c;
    return t[0];
  endfunction

  function automatic int predict(input logic [W-1:0] req, input logic [W-1:0] hld, input bit rdy,
                                 input bit rst);
    if (rst) return -1;
    if (m_wout && !rdy) return -1;
    if (has(hld, m_cur)) return has(req, m_cur) ? m_cur : -1;
    if (has(req, m_cur) && m_run < LIMIT) return m_cur;
    for (int i = 1; i <= W; i++) begin
      if (has(req, (m_cur + i) % W)) return (m_cur + i) % W;
    end
    return -1;
  endfunction

  task automatic push_words(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      fifo[c].push_back({8'(c), 24'(seq)});
      seq++;
    end
  endtask

  task automatic clear_fifos();
    for (int c = 0; c < W; c++) fifo[c].delete();
  endtask

  function automatic int fifo_total();
    int t = 0;
    for (int c = 0; c < W; c++) t += fifo[c].size();
    return t;
  endfunction

  task automatic drive();
    logic [W*DW-1:0] din;
    logic [W*DW-1:0] tmp;
    cur_req = '0;
    din     = '0;
    for (int c = 0; c < W; c++) begin
      tmp = '0;
      if (fifo[c].size() > 0) begin
        tmp[DW-1:0] = fifo[c][0];
        if (has(mask, c)) cur_req = cur_req | (W'(1) << c);
      end else begin
        tmp[DW-1:0] = $urandom;
      end
      din = din | (tmp << (c * DW));
    end
    bus.WRITE_REQ = cur_req;
    bus.HOLD_REQ  = hold;
    bus.READY_OUT = ready;
    bus.DATA_IN   = din;
  endtask

  task automatic step(input bit rst_v);
    int           pred;
    logic [W-1:0] expv;
    @(posedge CLK);
    #1;
    RST = rst_v;
    drive();
    @(negedge CLK);
    pred = predict(cur_req, hold, ready, RST);
    expv = (pred < 0) ? '0 : (W'(1) << pred);
    n_cmp++;
    if (bus.READ_GRANT !== expv) begin
      n_err++;
      $display("FAIL read_grant: got %b expected %b", bus.READ_GRANT, expv);
    end
    if (RST) begin
      m_cur  = W - 1;
      m_run  = 1;
      m_wout = 0;
      exp_q.delete();
    end else if (!m_wout || ready) begin
      m_wout = (pred >= 0);
      if (pred >= 0) begin
        exp_q.push_back('{data: fifo[pred][0], ch: pred});
        void'(fifo[pred].pop_front());
        m_run = (pred == m_cur) ? ((m_run + 1 > LIMIT) ? LIMIT : m_run + 1) : 1;
        m_cur = pred;
      end
    end
    last_ch = pred;
  endtask

  task automatic do_reset();
    mask  = '0;
    hold  = '0;
    ready = 1'b1;
    clear_fifos();
    step(1);
    step(1);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks the freeze under backpressure.
  logic [31:0]    p_data;
  logic [3:0]     p_ch;
  bit             p_wout, p_ready, p_valid = 0;
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (p_valid && p_wout && !p_ready) begin
        n_cmp++;
        if (bus.WRITE_OUT !== 1'b1 || bus.DATA_OUT !== p_data || bus.ACTIVE_CH !== p_ch) begin
          n_err++;
          $display("FAIL stall_freeze: got wo=%b d=%h ch=%0d expected wo=1 d=%h ch=%0d",
                   bus.WRITE_OUT, bus.DATA_OUT, bus.ACTIVE_CH, p_data, p_ch);
        end
      end
      if (bus.WRITE_OUT && bus.READY_OUT) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL transfer_unexpected: got d=%h expected no word", bus.DATA_OUT);
        end else begin
          e = exp_q.pop_front();
          if (bus.DATA_OUT !== e.data || bus.ACTIVE_CH !== 4'(e.ch)) begin
            n_err++;
            $display("FAIL transfer: got d=%h ch=%0d expected d=%h ch=%0d",
                     bus.DATA_OUT, bus.ACTIVE_CH, e.data, e.ch);
          end
        end
      end
    end
    p_wout  = bus.WRITE_OUT;
    p_ready = bus.READY_OUT;
    p_data  = bus.DATA_OUT;
    p_ch    = bus.ACTIVE_CH;
    p_valid = !RST;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int k;
    bit ok;
    bus.WRITE_REQ = '0;
    bus.HOLD_REQ  = '0;
    bus.READY_OUT = 1'b1;
    bus.DATA_IN   = '0;
    m_cur = W - 1; m_run = 1; m_wout = 0;

    // Reset: requests present but no grant while RST is high.
    do_reset();
    push_words(3, 2);
    mask = '1;
    step(1);
    step(1);
    clear_fifos();
    mask = '0;
    step(0);
    chk("reset_write_out", bus.WRITE_OUT, 0);
    chk("reset_data_out", bus.DATA_OUT, 0);
    chk("reset_active_ch", bus.ACTIVE_CH, W - 1);

    // Single requester: ch2 with A0..A4.
    do_reset();
    for (int i = 0; i < 5; i++) fifo[2].push_back(32'hA0 + 32'(i));
    mask = W'(1) << 2;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      step(0);
      if (last_ch == 2) cnt++;
    end
    chk("single_grant_count", cnt, 5);
    chk("single_active_ch", bus.ACTIVE_CH, 2);
    chk("single_last_word", bus.DATA_OUT, 32'hA4);

    // Burst rotation between ch0 and ch5.
    do_reset();
    push_words(0, 20);
    push_words(5, 20);
    mask = (W'(1) << 0) | (W'(1) << 5);
    k = 0;
    for (int i = 0; i < 100 && k < 3 * LIMIT; i++) begin
      step(0);
      if (last_ch >= 0) begin
        chk("burst_order", last_ch, ((k / LIMIT) % 2) ? 5 : 0);
        k++;
      end
    end
    chk("burst_done", k, 3 * LIMIT);

    // HOLD stall on ch3 while ch4 requests.
    do_reset();
    push_words(3, 10);
    push_words(4, 10);
    mask = (W'(1) << 3) | (W'(1) << 4);
    hold = W'(1) << 3;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step(0);
      ok = (last_ch == 3);
    end
    chk("hold_first_grant", ok, 1);
    mask = W'(1) << 4;
    for (int i = 0; i < 3; i++) begin
      step(0);
      chk("hold_stall", last_ch, -1);
    end
    mask = (W'(1) << 3) | (W'(1) << 4);
    step(0);
    chk("hold_resume", last_ch, 3);
    step(0);
    chk("hold_keep", last_ch, 3);
    hold = '0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step(0);
      ok = (last_ch == 4);
    end
    chk("hold_release_ch4", ok, 1);

    // Backpressure mid-stream, then drain with sequence compare.
    do_reset();
    push_words(1, 12);
    push_words(6, 12);
    mask = (W'(1) << 1) | (W'(1) << 6);
    for (int i = 0; i < 3; i++) step(0);
    ready = 0;
    for (int i = 0; i < 5; i++) begin
      step(0);
      chk("bp_no_grant", last_ch, -1);
    end
    ready = 1;
    for (int i = 0; i < 60 && (fifo_total() != 0 || exp_q.size() != 0); i++) step(0);
    step(0);
    chk("bp_drained", fifo_total() + exp_q.size(), 0);

    // Wrap-around: cur=10, requests on ch1 and ch9 -> ch1.
    do_reset();
    push_words(10, 1);
    mask = '1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step(0);
      ok = (last_ch == 10);
    end
    chk("wrap_cur10", ok, 1);
    push_words(1, 2);
    push_words(9, 2);
    ok = 0;
    k = -1;
    for (int i = 0; i < 10 && !ok; i++) begin
      step(0);
      if (last_ch >= 0) begin
        ok = 1;
        k = last_ch;
      end
    end
    chk("wrap_next", k, 1);

    // Reset while a word is stalled on the output.
    do_reset();
    push_words(7, 10);
    mask = W'(1) << 7;
    for (int i = 0; i < 3; i++) step(0);
    ready = 0;
    step(0);
    chk("rst_mid_wout_before", bus.WRITE_OUT, 1);
    step(1);
    push_words(0, 3);
    mask = (W'(1) << 0) | (W'(1) << 7);
    ready = 1;
    step(0);
    chk("rst_mid_write_out", bus.WRITE_OUT, 0);
    chk("rst_mid_active_ch", bus.ACTIVE_CH, W - 1);
    chk("rst_mid_first", last_ch, 0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < W; c++) begin
        if (fifo[c].size() < 2 && $urandom_range(0, 3) == 0) push_words(c, $urandom_range(1, 6));
      end
      mask  = W'($urandom);
      hold  = ($urandom_range(0, 5) == 0) ? (W'(1) << $urandom_range(0, W - 1)) : '0;
      ready = ($urandom_range(0, 3) != 0);
      step(0);
    end
    mask  = '1;
    hold  = '0;
    ready = 1;
    for (int i = 0; i < 1000 && (fifo_total() != 0 || exp_q.size() != 0); i++) step(0);
    step(0);
    chk("random_drained", fifo_total() + exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
